pipe_hazard_ctrl: RTL and testbench

Central pipeline controller for the 16-bit 5-stage core. It sequences the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, producing per-stage enable and flush controls and EX operand forwarding selects. Its sources are register-address and control fields from each stage, the EX branch outcome and the data-memory ready handshake. It also runs a memory-wait state machine with a timeout watchdog, and optional stall and flush performance counters.

---
 rtl/pipe_hazard_ctrl_if.sv | 67 ++++++
 rtl/pipe_hazard_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard control bundle: stage register fields in, enables/flushes/forwarding out.
// Perf counter signals exist only when HAZARD_PERF_EN is defined.
interface pipe_hazard_ctrl_if;
  logic [3:0]  id_rs1;
  logic [3:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [3:0]  ex_rs1;
  logic [3:0]  ex_rs2;
  logic [3:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_branch_taken;
  logic [3:0]  mem_rd;
  logic        mem_reg_write;
  logic        mem_mem_to_reg;
  logic        mem_access;
  logic [3:0]  wb_rd;
  logic        wb_reg_write;
  logic        dmem_ready;

  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_mem_en;
  logic        mem_wb_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        mem_wb_flush;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        mem_timeout;

`ifdef HAZARD_PERF_EN
  logic        perf_clr;
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  modport master (
`ifdef HAZARD_PERF_EN
    output perf_clr,
    input  stall_cycles, flush_count,
`endif
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read, ex_branch_taken,
    output mem_rd, mem_reg_write, mem_mem_to_reg, mem_access,
    output wb_rd, wb_reg_write, dmem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_flush, mem_wb_flush,
    input  fwd_a, fwd_b, mem_timeout
  );

  modport slave (
`ifdef HAZARD_PERF_EN
    input  perf_clr,
    output stall_cycles, flush_count,
`endif
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read, ex_branch_taken,
    input  mem_rd, mem_reg_write, mem_mem_to_reg, mem_access,
    input  wb_rd, wb_reg_write, dmem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_flush, mem_wb_flush,
    output fwd_a, fwd_b, mem_timeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: combinational enables/flushes/forwarding, memory-wait FSM
// with timeout watchdog (mem_timeout registered). Optional perf counters under HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave pif
);

  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       mem_timeout_q, mem_timeout_d;

  logic load_use;
  logic mem_stall;
  logic freeze;
  logic advance;
  logic drop;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_wb_flush;
  logic [1:0] fwd_a, fwd_b;

  // MEM-stage ALU result wins over WB; loads in MEM have no value yet.
  always_comb begin
    fwd_a = 2'b00;
    if (pif.mem_reg_write && !pif.mem_mem_to_reg && pif.mem_rd != 4'd0 && pif.mem_rd == pif.ex_rs1)
      fwd_a = 2'b01;
    else if (pif.wb_reg_write && pif.wb_rd != 4'd0 && pif.wb_rd == pif.ex_rs1)
      fwd_a = 2'b10;

    fwd_b = 2'b00;
    if (pif.mem_reg_write && !pif.mem_mem_to_reg && pif.mem_rd != 4'd0 && pif.mem_rd == pif.ex_rs2)
      fwd_b = 2'b01;
    else if (pif.wb_reg_write && pif.wb_rd != 4'd0 && pif.wb_rd == pif.ex_rs2)
      fwd_b = 2'b10;
  end

  assign load_use = pif.ex_mem_read && pif.ex_reg_write && (pif.ex_rd != 4'd0) &&
                    ((pif.id_use_rs1 && pif.id_rs1 == pif.ex_rd) ||
                     (pif.id_use_rs2 && pif.id_rs2 == pif.ex_rd));
  assign mem_stall = pif.mem_access && !pif.dmem_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_timeout_d = 1'b0;
    freeze        = 1'b0;
    advance       = 1'b0;
    drop          = 1'b0;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_flush  = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
          cnt_d   = 8'd0;
        end else begin
          advance = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Ready on the expiry cycle counts as a normal completion.
        if (pif.dmem_ready) begin
          advance = 1'b1;
          state_d = RUN;
          cnt_d   = 8'd0;
        end else if (cnt_q >= CNT_LAST) begin
          advance       = 1'b1;
          drop          = 1'b1;
          mem_timeout_d = 1'b1;
          state_d       = RUN;
          cnt_d         = 8'd0;
        end else begin
          freeze = 1'b1;
          cnt_d  = cnt_q + 8'd1;
        end
      end
    endcase

    // The MEM/WB register still loads during a freeze, but with a bubble.
    if (freeze) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end

    // Branch/load-use held during a wait are acted on at the release cycle.
    if (advance) begin
      if (pif.ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end

    if (drop) mem_wb_flush = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      cnt_q         <= 8'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign pif.pc_en        = pc_en;
  assign pif.if_id_en     = if_id_en;
  assign pif.id_ex_en     = id_ex_en;
  assign pif.ex_mem_en    = ex_mem_en;
  assign pif.mem_wb_en    = mem_wb_en;
  assign pif.if_id_flush  = if_id_flush;
  assign pif.id_ex_flush  = id_ex_flush;
  assign pif.mem_wb_flush = mem_wb_flush;
  assign pif.fwd_a        = fwd_a;
  assign pif.fwd_b        = fwd_b;
  assign pif.mem_timeout  = mem_timeout_q;

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;

  // Clear beats increment; both counters stick at all-ones.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (pif.perf_clr) begin
      stall_cycles_d = 16'd0;
      flush_count_d  = 16'd0;
    end else begin
      if (!pc_en && stall_cycles_q != 16'hFFFF)
        stall_cycles_d = stall_cycles_q + 16'd1;
      if (if_id_flush && flush_count_q != 16'hFFFF)
        flush_count_d = flush_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= 16'd0;
      flush_count_q  <= 16'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign pif.stall_cycles = stall_cycles_q;
  assign pif.flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random cycles, all checked against a
// rule-level reference model (freeze-count based wait tracking).
module tb_pipe_hazard_ctrl;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if pif();
  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .pif(pif));

  typedef struct {
    logic       rst;
    logic [3:0] id_rs1, id_rs2;
    logic       id_use_rs1, id_use_rs2;
    logic [3:0] ex_rs1, ex_rs2, ex_rd;
    logic       ex_reg_write, ex_mem_read, ex_branch_taken;
    logic [3:0] mem_rd;
    logic       mem_reg_write, mem_mem_to_reg, mem_access;
    logic [3:0] wb_rd;
    logic       wb_reg_write, dmem_ready, perf_clr;
  } stim_t;

  stim_t s;
  int    checks = 0;
  int    errors = 0;
  int    frozen = 0;      // freeze cycles already spent on the current access
  logic  exp_to = 1'b0;
  int    exp_stall = 0;
  int    exp_flush = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [3:0] rs);
    if (s.mem_reg_write && !s.mem_mem_to_reg && s.mem_rd != 0 && s.mem_rd == rs) return 2'b01;
    if (s.wb_reg_write && s.wb_rd != 0 && s.wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic idle();
    s = '{default: '0};
  endtask

  task automatic step();
    bit freeze, drop, lu;
    logic [4:0] en;
    logic [2:0] fl;
    @(posedge clk);
    #1;
    chk("mem_timeout", 16'(pif.mem_timeout), 16'(exp_to));
`ifdef HAZARD_PERF_EN
    chk("stall_cycles", pif.stall_cycles, 16'(exp_stall));
    chk("flush_count", pif.flush_count, 16'(exp_flush));
    pif.perf_clr = s.perf_clr;
`endif
    rst = s.rst;
    pif.id_rs1 = s.id_rs1;             pif.id_rs2 = s.id_rs2;
    pif.id_use_rs1 = s.id_use_rs1;     pif.id_use_rs2 = s.id_use_rs2;
    pif.ex_rs1 = s.ex_rs1;             pif.ex_rs2 = s.ex_rs2;
    pif.ex_rd = s.ex_rd;               pif.ex_reg_write = s.ex_reg_write;
    pif.ex_mem_read = s.ex_mem_read;   pif.ex_branch_taken = s.ex_branch_taken;
    pif.mem_rd = s.mem_rd;             pif.mem_reg_write = s.mem_reg_write;
    pif.mem_mem_to_reg = s.mem_mem_to_reg; pif.mem_access = s.mem_access;
    pif.wb_rd = s.wb_rd;               pif.wb_reg_write = s.wb_reg_write;
    pif.dmem_ready = s.dmem_ready;
    if (s.rst) frozen = 0;
    #1;
    lu = s.ex_mem_read && s.ex_reg_write && s.ex_rd != 0 &&
         ((s.id_use_rs1 && s.id_rs1 == s.ex_rd) || (s.id_use_rs2 && s.id_rs2 == s.ex_rd));
    freeze = 0;
    drop = 0;
    if (frozen == 0) freeze = s.mem_access && !s.dmem_ready;
    else if (!s.dmem_ready) begin
      if (frozen >= TO) drop = 1;
      else freeze = 1;
    end
    en = 5'b11111;   // {pc, if_id, id_ex, ex_mem, mem_wb}
    fl = 3'b000;     // {if_id, id_ex, mem_wb}
    if (freeze) begin
      en = 5'b00001;
      fl = 3'b001;
    end else begin
      if (s.ex_branch_taken) fl = 3'b110;
      else if (lu) begin
        en = 5'b00111;
        fl = 3'b010;
      end
      if (drop) fl[0] = 1'b1;
    end
    chk("enables", 16'({pif.pc_en, pif.if_id_en, pif.id_ex_en, pif.ex_mem_en, pif.mem_wb_en}), 16'(en));
    chk("flushes", 16'({pif.if_id_flush, pif.id_ex_flush, pif.mem_wb_flush}), 16'(fl));
    chk("fwd_a", 16'(pif.fwd_a), 16'(ref_fwd(s.ex_rs1)));
    chk("fwd_b", 16'(pif.fwd_b), 16'(ref_fwd(s.ex_rs2)));
    if (s.rst) begin
      frozen = 0;
      exp_to = 1'b0;
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      exp_to = drop;
      frozen = freeze ? frozen + 1 : 0;
      if (s.perf_clr) begin
        exp_stall = 0;
        exp_flush = 0;
      end else begin
        if (!en[4] && exp_stall < 16'hFFFF) exp_stall++;
        if (fl[2] && exp_flush < 16'hFFFF) exp_flush++;
      end
    end
  endtask

  initial begin
    // Reset state: RUN rules apply while rst is high
    idle(); s.rst = 1; step(); step();
    chk("rst_pc_en", 16'(pif.pc_en), 16'd1);
    chk("rst_mem_timeout", 16'(pif.mem_timeout), 16'd0);
    idle(); step();

    // Load-use: one bubble, then free-running
    idle(); s.ex_mem_read = 1; s.ex_reg_write = 1; s.ex_rd = 3; s.id_rs1 = 3; s.id_use_rs1 = 1; step();
    chk("lu_pc_en", 16'(pif.pc_en), 16'd0);
    chk("lu_if_id_en", 16'(pif.if_id_en), 16'd0);
    chk("lu_id_ex_flush", 16'(pif.id_ex_flush), 16'd1);
    idle(); step();
    chk("lu_after_pc_en", 16'(pif.pc_en), 16'd1);

    // Forwarding priority and r0
    idle(); s.mem_rd = 5; s.wb_rd = 5; s.mem_reg_write = 1; s.wb_reg_write = 1; s.ex_rs1 = 5; step();
    chk("fwd_mem", 16'(pif.fwd_a), 16'd1);
    s.mem_mem_to_reg = 1; step();
    chk("fwd_wb", 16'(pif.fwd_a), 16'd2);
    s.mem_rd = 0; s.wb_rd = 0; s.ex_rs1 = 0; s.mem_mem_to_reg = 0; step();
    chk("fwd_r0", 16'(pif.fwd_a), 16'd0);

    // Memory wait: 3 freeze cycles then release
    idle(); s.mem_access = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_mem_wb_flush", 16'(pif.mem_wb_flush), 16'd1);
      chk("wait_pc_en", 16'(pif.pc_en), 16'd0);
    end
    s.dmem_ready = 1; step();
    chk("wait_release_pc_en", 16'(pif.pc_en), 16'd1);
    chk("wait_release_flush", 16'(pif.mem_wb_flush), 16'd0);
    idle(); step(); step();

    // Timeout: 4 freezes, release with flush, one-cycle pulse
    idle(); s.mem_access = 1;
    for (int i = 0; i < TO; i++) step();
    step();
    chk("to_release_pc_en", 16'(pif.pc_en), 16'd1);
    chk("to_release_flush", 16'(pif.mem_wb_flush), 16'd1);
    idle(); step();
    chk("to_pulse_hi", 16'(pif.mem_timeout), 16'd1);
    step();
    chk("to_pulse_lo", 16'(pif.mem_timeout), 16'd0);

    // Reset mid-wait returns to RUN
    idle(); s.mem_access = 1; step(); step();
    idle(); s.rst = 1; step();
    idle(); step();
    s.mem_access = 1; s.dmem_ready = 1; step();
    chk("post_rst_pc_en", 16'(pif.pc_en), 16'd1);

    // Branch with load-use; branch held through a wait
    idle(); s.ex_branch_taken = 1; s.ex_mem_read = 1; s.ex_reg_write = 1; s.ex_rd = 2;
    s.id_rs2 = 2; s.id_use_rs2 = 1; step();
    chk("br_lu_pc_en", 16'(pif.pc_en), 16'd1);
    chk("br_lu_flushes", 16'({pif.if_id_flush, pif.id_ex_flush}), 16'd3);
    idle(); s.ex_branch_taken = 1; s.mem_access = 1; step(); step();
    chk("br_wait_if_id_flush", 16'(pif.if_id_flush), 16'd0);
    s.dmem_ready = 1; step();
    chk("br_release_if_id_flush", 16'(pif.if_id_flush), 16'd1);
    idle(); step();

`ifdef HAZARD_PERF_EN
    idle(); s.perf_clr = 1; step();
    idle(); s.ex_mem_read = 1; s.ex_reg_write = 1; s.ex_rd = 7; s.id_rs1 = 7; s.id_use_rs1 = 1;
    for (int i = 0; i < 3; i++) step();
    idle(); s.ex_branch_taken = 1; step(); step();
    idle(); step();
    chk("perf_stalls", pif.stall_cycles, 16'd3);
    chk("perf_flushes", pif.flush_count, 16'd2);
    s.perf_clr = 1; step();
    idle(); step();
    chk("perf_clr_stalls", pif.stall_cycles, 16'd0);
    s.ex_mem_read = 1; s.ex_reg_write = 1; s.ex_rd = 7; s.id_rs1 = 7; s.id_use_rs1 = 1;
    for (int i = 0; i < 65540; i++) step();
    idle(); step();
    chk("perf_sat", pif.stall_cycles, 16'hFFFF);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      s.rst            = ($urandom_range(0, 99) == 0);
      s.id_rs1         = 4'($urandom_range(0, 3));
      s.id_rs2         = 4'($urandom_range(0, 3));
      s.id_use_rs1     = 1'($urandom);
      s.id_use_rs2     = 1'($urandom);
      s.ex_rs1         = 4'($urandom_range(0, 3));
      s.ex_rs2         = 4'($urandom_range(0, 3));
      s.ex_rd          = 4'($urandom_range(0, 3));
      s.ex_reg_write   = 1'($urandom);
      s.ex_mem_read    = 1'($urandom);
      s.ex_branch_taken = ($urandom_range(0, 5) == 0);
      s.mem_rd         = 4'($urandom_range(0, 3));
      s.mem_reg_write  = 1'($urandom);
      s.mem_mem_to_reg = 1'($urandom);
      s.mem_access     = ($urandom_range(0, 2) == 0);
      s.wb_rd          = 4'($urandom_range(0, 3));
      s.wb_reg_write   = 1'($urandom);
      s.dmem_ready     = ($urandom_range(0, 9) < 3);
      s.perf_clr       = ($urandom_range(0, 49) == 0);
      step();
    end

    idle(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
